mem_stage: RTL and testbench

Memory stage of the 5-stage pipeline. It sits between the EX/MEM latch and the MEM/WB latch.
- Turns EX/MEM load/store controls into a dcache request handshake (REN/WEN held until dhit).
- Stalls upstream while the access is outstanding.
- Presents the captured load data plus the pass-through fields to the MEM/WB latch, with that latch's en/flush.

---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/mem_req_fsm.sv | 121 ++++++++++++
 rtl/mem_stage.sv | 92 +++++++++
 tb/tb_mem_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, register index and the memory-stage FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } memstate_t;

  // Word accesses must sit on a 4-byte boundary.
  function automatic logic word_misaligned(input word_t addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// Data-cache request sequencer for the memory stage. Owns the IDLE/ACCESS/DONE
// state, the captured load word and the stall / MEM-WB enable generation.
// Optional macro MEM_WATCHDOG_EN adds an ACCESS-cycle counter and a sticky
// mem_err output.
module mem_req_fsm
  import cpu_types_pkg::*;
#(
  parameter int WATCHDOG_LIMIT = 255
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      mem_read,
  input  logic      mem_write,
  input  logic      mis,
  input  logic      flush,
  input  logic      dhit,
  input  word_t     dmemload,
  output memstate_t state,
  output word_t     load_q,
  output logic      dmemREN,
  output logic      dmemWEN,
  output logic      mem_stall,
  output logic      memwb_en,
  output logic      memwb_flush,
  output logic      mem_misalign
`ifdef MEM_WATCHDOG_EN
  ,
  output logic      mem_err
`endif
);

  memstate_t next_state;
  logic      memop;

  assign memop = mem_read | mem_write;

  // State register and load capture; the word is latched on the hit edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      load_q <= '0;
    end else begin
      state <= next_state;
      if (state == ACCESS && dhit) begin
        load_q <= dmemload;
      end
    end
  end

  // Next state and request/handshake outputs; all outputs are held low in reset.
  always_comb begin
    next_state   = state;
    dmemREN      = 1'b0;
    dmemWEN      = 1'b0;
    mem_stall    = 1'b0;
    memwb_en     = 1'b0;
    memwb_flush  = 1'b0;
    mem_misalign = 1'b0;
    if (nRST) begin
      case (state)
        IDLE: begin
          memwb_en    = 1'b1;
          memwb_flush = flush;
          if (memop && !flush) begin
            if (mis) begin
              mem_misalign = 1'b1;
            end else begin
              mem_stall  = 1'b1;
              memwb_en   = 1'b0;
              next_state = ACCESS;
            end
          end
        end
        ACCESS: begin
          dmemREN   = mem_read & ~mem_write;
          dmemWEN   = mem_write;
          mem_stall = 1'b1;
          if (dhit) begin
            next_state = DONE;
          end
        end
        DONE: begin
          memwb_en   = 1'b1;
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

`ifdef MEM_WATCHDOG_EN
  localparam int WD_W = (WATCHDOG_LIMIT > 255) ? $clog2(WATCHDOG_LIMIT + 1) : 8;
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(WATCHDOG_LIMIT);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;
  logic            wd_hit;

  // The count holds the number of ACCESS cycles so far, including the current one.
  assign wd_hit  = (state == ACCESS) && (wd_cnt >= WD_LIM);
  assign mem_err = err_q | wd_hit;

  // Counter restarts at 1 on entry to ACCESS, saturates, and trips a sticky error.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == IDLE && next_state == ACCESS) begin
        wd_cnt <= WD_W'(1);
      end else if (state == ACCESS && wd_cnt != '1) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage pipeline: issues dcache requests for loads and
// stores, stalls upstream while they are outstanding, and feeds the MEM/WB latch.
// Optional macro MEM_WATCHDOG_EN exposes the mem_err watchdog output.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int ALIGN_CHECK    = 1,
  parameter int WATCHDOG_LIMIT = 255
) (
  input  logic     CLK,
  input  logic     nRST,
  input  logic     MemRead_i,
  input  logic     MemWrite_i,
  input  word_t    OutputPort_i,
  input  word_t    storedata_i,
  input  word_t    imm_i,
  input  word_t    pc4_i,
  input  regbits_t wsel_i,
  input  logic     RegWr_i,
  input  logic     halt_i,
  input  logic [1:0] MemToReg_i,
  input  logic     flush_i,
  input  logic     dhit,
  input  word_t    dmemload,
  output logic     dmemREN,
  output logic     dmemWEN,
  output word_t    dmemaddr,
  output word_t    dmemstore,
  output word_t    imm_o,
  output word_t    pc4_o,
  output word_t    OutputPort_o,
  output word_t    dmemload_o,
  output regbits_t wsel_o,
  output logic     RegWr_o,
  output logic     halt_o,
  output logic [1:0] MemToReg_o,
  output logic     memwb_en,
  output logic     memwb_flush,
  output logic     mem_stall,
  output logic     mem_misalign
`ifdef MEM_WATCHDOG_EN
  ,
  output logic     mem_err
`endif
);

  memstate_t state;
  word_t     load_q;
  logic      mis;

  assign mis = (ALIGN_CHECK != 0) && word_misaligned(OutputPort_i);

  mem_req_fsm #(
    .WATCHDOG_LIMIT(WATCHDOG_LIMIT)
  ) u_req_fsm (
    .CLK         (CLK),
    .nRST        (nRST),
    .mem_read    (MemRead_i),
    .mem_write   (MemWrite_i),
    .mis         (mis),
    .flush       (flush_i),
    .dhit        (dhit),
    .dmemload    (dmemload),
    .state       (state),
    .load_q      (load_q),
    .dmemREN     (dmemREN),
    .dmemWEN     (dmemWEN),
    .mem_stall   (mem_stall),
    .memwb_en    (memwb_en),
    .memwb_flush (memwb_flush),
    .mem_misalign(mem_misalign)
`ifdef MEM_WATCHDOG_EN
    ,
    .mem_err     (mem_err)
`endif
  );

  // Pass-through fields; a suppressed misaligned access must not write back.
  always_comb begin
    dmemaddr     = OutputPort_i;
    dmemstore    = storedata_i;
    imm_o        = imm_i;
    pc4_o        = pc4_i;
    OutputPort_o = OutputPort_i;
    wsel_o       = wsel_i;
    halt_o       = halt_i;
    MemToReg_o   = MemToReg_i;
    RegWr_o      = RegWr_i & ~mem_misalign;
    dmemload_o   = (state == DONE) ? load_q : dmemload;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues random EX/MEM instructions and
// pushes the expected MEM/WB result; a monitor pops and compares on memwb_en.
module tb_mem_stage;
  import cpu_types_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       MemRead_i = 1'b0, MemWrite_i = 1'b0, RegWr_i = 1'b0, halt_i = 1'b0, flush_i = 1'b0;
  word_t      OutputPort_i = '0, storedata_i = '0, imm_i = '0, pc4_i = '0;
  regbits_t   wsel_i = '0;
  logic [1:0] MemToReg_i = '0;
  logic       dhit = 1'b0;
  word_t      dmemload = '0;
  logic       dmemREN, dmemWEN, RegWr_o, halt_o, memwb_en, memwb_flush, mem_stall, mem_misalign;
  word_t      dmemaddr, dmemstore, imm_o, pc4_o, OutputPort_o, dmemload_o;
  regbits_t   wsel_o;
  logic [1:0] MemToReg_o;
`ifdef MEM_WATCHDOG_EN
  logic       mem_err;
`endif

  always #5 CLK = ~CLK;

  mem_stage dut (
    .CLK(CLK), .nRST(nRST), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .OutputPort_i(OutputPort_i), .storedata_i(storedata_i), .imm_i(imm_i), .pc4_i(pc4_i),
    .wsel_i(wsel_i), .RegWr_i(RegWr_i), .halt_i(halt_i), .MemToReg_i(MemToReg_i),
    .flush_i(flush_i), .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .imm_o(imm_o), .pc4_o(pc4_o),
    .OutputPort_o(OutputPort_o), .dmemload_o(dmemload_o), .wsel_o(wsel_o), .RegWr_o(RegWr_o),
    .halt_o(halt_o), .MemToReg_o(MemToReg_o), .memwb_en(memwb_en), .memwb_flush(memwb_flush),
    .mem_stall(mem_stall), .mem_misalign(mem_misalign)
`ifdef MEM_WATCHDOG_EN
    , .mem_err(mem_err)
`endif
  );

  typedef struct {
    word_t      imm, pc4, outp, load;
    regbits_t   wsel;
    logic       regwr, halt, flush, misalign, ren, wen;
    logic [1:0] m2r;
    int         stall, req;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  int    check_count = 0;
  int    pass_count = 0;
  word_t cache_mem[word_t];
  word_t model_mem[word_t];
  int    cur_delay = 0;
  int    req_cnt = 0;
  int    stall_run = 0;
  logic  seen_ren = 1'b0, seen_wen = 1'b0, bad_req = 1'b0, mon_on = 1'b0, aborted = 1'b0;
  word_t req_addr0 = '0, req_data0 = '0;

  // Contents of a word never written: a fixed function of its address.
  function automatic word_t fresh_word(input word_t a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Data cache: answers a request after cur_delay extra cycles, random dhit otherwise.
  always @(negedge CLK) begin
    if (nRST && (dmemREN || dmemWEN)) begin
      if (req_cnt == 0) begin
        req_addr0 = dmemaddr;
        req_data0 = dmemstore;
      end else if (dmemaddr !== req_addr0 || (dmemWEN && dmemstore !== req_data0)) begin
        bad_req = 1'b1;
      end
      if (dmemREN && dmemWEN) bad_req = 1'b1;
      seen_ren = seen_ren | dmemREN;
      seen_wen = seen_wen | dmemWEN;
      req_cnt++;
      if (req_cnt - 1 >= cur_delay) begin
        dhit = 1'b1;
        if (dmemWEN) cache_mem[dmemaddr] = dmemstore;
        if (dmemREN) dmemload = cache_mem.exists(dmemaddr) ? cache_mem[dmemaddr] : fresh_word(dmemaddr);
        else dmemload = $urandom;
      end else begin
        dhit = 1'b0;
        dmemload = $urandom;
      end
    end else begin
      dhit = nRST ? 1'($urandom_range(0, 1)) : 1'b0;
      dmemload = $urandom;
    end
  end

  // Monitor: each MEM/WB enable retires the oldest expected instruction.
  always @(negedge CLK) begin
    if (!nRST) begin
      stall_run = 0;
    end else if (mon_on) begin
      if (mem_stall) stall_run++;
      if (memwb_en) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_memwb_en", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("imm_o", imm_o, mon_e.imm);
          checkOutput("pc4_o", pc4_o, mon_e.pc4);
          checkOutput("OutputPort_o", OutputPort_o, mon_e.outp);
          checkOutput("wsel_o", 32'(wsel_o), 32'(mon_e.wsel));
          checkOutput("RegWr_o", 32'(RegWr_o), 32'(mon_e.regwr));
          checkOutput("halt_o", 32'(halt_o), 32'(mon_e.halt));
          checkOutput("MemToReg_o", 32'(MemToReg_o), 32'(mon_e.m2r));
          checkOutput("memwb_flush", 32'(memwb_flush), 32'(mon_e.flush));
          checkOutput("mem_misalign", 32'(mem_misalign), 32'(mon_e.misalign));
          checkOutput("stall_cycles", 32'(stall_run), 32'(mon_e.stall));
          checkOutput("req_cycles", 32'(req_cnt), 32'(mon_e.req));
          checkOutput("saw_ren", 32'(seen_ren), 32'(mon_e.ren));
          checkOutput("saw_wen", 32'(seen_wen), 32'(mon_e.wen));
          checkOutput("req_stable", 32'(bad_req), 32'd0);
          if (mon_e.ren) checkOutput("dmemload_o", dmemload_o, mon_e.load);
        end
        stall_run = 0;
      end
    end
  end

  // kind: 0 ALU, 1 load, 2 store, 3 misaligned, 4 flush, 5 access with late flush
  task automatic applyStimulus(input int kind, input int delay);
    exp_t e;
    logic memop, mis, go, late, done;
    imm_i = $urandom; pc4_i = $urandom; storedata_i = $urandom;
    wsel_i = 5'($urandom); RegWr_i = 1'($urandom); halt_i = 1'($urandom);
    MemToReg_i = 2'($urandom);
    MemRead_i = 1'b0; MemWrite_i = 1'b0; flush_i = 1'b0; late = 1'b0;
    OutputPort_i = 32'h100 + 32'($urandom_range(0, 15)) * 4;
    case (kind)
      0: OutputPort_i = $urandom;
      1: MemRead_i = 1'b1;
      2: MemWrite_i = 1'b1;
      3: begin
        MemRead_i = 1'($urandom);
        MemWrite_i = ~MemRead_i;
        OutputPort_i = OutputPort_i + 32'($urandom_range(1, 3));
      end
      4: begin
        {MemRead_i, MemWrite_i} = 2'($urandom);
        flush_i = 1'b1;
      end
      default: begin
        {MemRead_i, MemWrite_i} = 2'($urandom_range(1, 3));
        late = (delay >= 1);
      end
    endcase
    memop = MemRead_i | MemWrite_i;
    mis   = OutputPort_i[1:0] != 2'b00;
    go    = memop && !mis && !flush_i;
    e.imm = imm_i; e.pc4 = pc4_i; e.outp = OutputPort_i; e.wsel = wsel_i;
    e.halt = halt_i; e.m2r = MemToReg_i; e.flush = flush_i;
    e.misalign = memop && mis && !flush_i;
    e.regwr = RegWr_i && !e.misalign;
    e.stall = go ? delay + 2 : 0;
    e.req   = go ? delay + 1 : 0;
    e.ren   = go && MemRead_i && !MemWrite_i;
    e.wen   = go && MemWrite_i;
    e.load  = '0;
    if (e.ren) e.load = model_mem.exists(OutputPort_i) ? model_mem[OutputPort_i] : fresh_word(OutputPort_i);
    if (e.wen) model_mem[OutputPort_i] = storedata_i;
    req_cnt = 0; seen_ren = 1'b0; seen_wen = 1'b0; bad_req = 1'b0;
    cur_delay = delay;
    exp_q.push_back(e);
    mon_on = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge CLK);
      if (!mem_stall) begin
        done = 1'b1;
        break;
      end
      @(posedge CLK);
      #1;
      if (late) flush_i = (c == 0);
    end
    if (!done) begin
      check_count++;
      $display("[TB] FAIL timeout: mem_stall still 1 after 64 cycles, expected release");
      aborted = 1'b1;
    end
    @(posedge CLK);
    #1;
  endtask

  // Reset while a load is outstanding: requests must drop at once.
  task automatic resetMidAccess();
    logic seen;
    mon_on = 1'b0;
    MemRead_i = 1'b1; MemWrite_i = 1'b0; flush_i = 1'b0; OutputPort_i = 32'h100;
    req_cnt = 0; cur_delay = 1000; seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (dmemREN) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("rst_pre_ren", 32'(seen), 32'd1);
    #2 nRST = 1'b0;
    #1;
    checkOutput("rst_mid_ren", 32'(dmemREN), 32'd0);
    checkOutput("rst_mid_wen", 32'(dmemWEN), 32'd0);
    checkOutput("rst_mid_stall", 32'(mem_stall), 32'd0);
    checkOutput("rst_mid_en", 32'(memwb_en), 32'd0);
    MemRead_i = 1'b0;
    @(posedge CLK);
    #1 nRST = 1'b1;
    @(negedge CLK);
    checkOutput("post_rst_en", 32'(memwb_en), 32'd1);
    checkOutput("post_rst_stall", 32'(mem_stall), 32'd0);
    checkOutput("post_rst_ren", 32'(dmemREN), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    MemRead_i = 1'b1; MemWrite_i = 1'b1; flush_i = 1'b1; OutputPort_i = 32'h102;
    #3;
    checkOutput("reset_ren", 32'(dmemREN), 32'd0);
    checkOutput("reset_wen", 32'(dmemWEN), 32'd0);
    checkOutput("reset_stall", 32'(mem_stall), 32'd0);
    checkOutput("reset_en", 32'(memwb_en), 32'd0);
    checkOutput("reset_flush", 32'(memwb_flush), 32'd0);
    checkOutput("reset_misalign", 32'(mem_misalign), 32'd0);
    MemRead_i = 1'b0; MemWrite_i = 1'b0; flush_i = 1'b0;
    @(posedge CLK);
    #1 nRST = 1'b1;
    @(posedge CLK);
    #1;
    applyStimulus(1, 3);
    applyStimulus(2, 0);
    applyStimulus(3, 0);
    applyStimulus(4, 0);
    applyStimulus(5, 2);
    applyStimulus(1, 0);
    for (int i = 0; i < 150 && !aborted; i++) begin
      applyStimulus(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
    end
    if (!aborted) resetMidAccess();
    for (int i = 0; i < 20 && !aborted; i++) begin
      applyStimulus(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
    end
    mon_on = 1'b0;
    if (!aborted) checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
